// File: rtl/fx_pkg.sv
// Shared types and constants for the fx_* effects chain.
package fx_pkg;

   typedef enum logic [2:0] {
      CLOSED,
      ATTACK,
      OPEN,
      HOLD,
      RELEASE
   } gate_state_t;

   localparam int GATE_UNITY = 32768;
   localparam int GATE_W     = 16;

endpackage

// File: rtl/fx_env_follower.sv
// Stereo peak envelope follower: abs of each channel, stereo max, peak hold with
// exponential decay. env_next is the value the envelope takes on this sample.
module fx_env_follower
   import fx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ENV_SH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [1:0][DATA_W-1:0] audio_in,
   input  logic                   sample_valid,
   output logic [DATA_W-1:0]      env_next
);

   logic [DATA_W-1:0] env_q;
   logic [DATA_W-1:0] mag_l;
   logic [DATA_W-1:0] mag_r;
   logic [DATA_W-1:0] mag;

   // Unsigned magnitude, so the most negative sample maps to 2^(DATA_W-1)
   always_comb begin
      mag_l    = audio_in[0][DATA_W-1] ? (~audio_in[0] + DATA_W'(1)) : audio_in[0];
      mag_r    = audio_in[1][DATA_W-1] ? (~audio_in[1] + DATA_W'(1)) : audio_in[1];
      mag      = (mag_l >= mag_r) ? mag_l : mag_r;
      env_next = (mag >= env_q) ? mag : env_q - (env_q >> ENV_SH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         env_q <= '0;
      end else if (sample_valid) begin
         env_q <= env_next;
      end
   end

endmodule

// File: rtl/fx_noise_gate.sv
// Stereo noise gate with attack/hold/release gain ramp driven by a shared peak envelope.
// Build option: define NOISE_GATE_HYST_EN to close at half the open threshold.
module fx_noise_gate
   import fx_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int PARAM_W      = 7,
   parameter int HOLD_SAMPLES = 480,
   parameter int ATTACK_STEP  = 1024,
   parameter int RELEASE_STEP = 128,
   parameter int ENV_SH       = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [1:0][DATA_W-1:0] audio_in,
   input  logic                   sample_valid,
   input  logic [PARAM_W-1:0]     threshold,
   input  logic                   bypass,
   output logic [1:0][DATA_W-1:0] audio_out,
   output logic                   out_valid,
   output logic                   gate_open
);

   localparam int HC_W = $clog2(HOLD_SAMPLES + 1);
   localparam int PW   = DATA_W + 17;

   localparam logic [GATE_W-1:0] UNITY     = GATE_W'(GATE_UNITY);
   localparam logic [GATE_W:0]   UNITY_X   = (GATE_W+1)'(GATE_UNITY);
   localparam logic [GATE_W:0]   ATTACK_X  = (GATE_W+1)'(ATTACK_STEP);
   localparam logic [GATE_W-1:0] RELEASE_G = GATE_W'(RELEASE_STEP);
   localparam logic [HC_W-1:0]   HOLD_LOAD = HC_W'(HOLD_SAMPLES - 1);

   gate_state_t       state_q, state_d;
   logic [GATE_W-1:0] g_q, g_d, g_att, g_rel;
   logic [GATE_W:0]   g_sum;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0] env_next, thr_open, thr_close;
   logic              is_open, is_below;

   logic signed [PW-1:0]     smp_x [2];
   logic signed [PW-1:0]     gain_x;
   logic signed [PW-1:0]     prod [2];
   logic [1:0][DATA_W-1:0]   scaled;

   fx_env_follower #(
      .DATA_W (DATA_W),
      .ENV_SH (ENV_SH)
   ) u_env (
      .clk          (clk),
      .reset_n      (reset_n),
      .audio_in     (audio_in),
      .sample_valid (sample_valid),
      .env_next     (env_next)
   );

   always_comb begin
      thr_open = DATA_W'(threshold) << (DATA_W - 1 - PARAM_W);
`ifdef NOISE_GATE_HYST_EN
      thr_close = thr_open >> 1;
`else
      thr_close = thr_open;
`endif
      is_open  = (env_next >= thr_open);
      is_below = (env_next < thr_close);
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      hold_d  = hold_q;
      g_sum   = {1'b0, g_q} + ATTACK_X;
      g_att   = (g_sum >= UNITY_X) ? UNITY : g_sum[GATE_W-1:0];
      g_rel   = (g_q > RELEASE_G) ? (g_q - RELEASE_G) : '0;
      case (state_q)
         // The opening sample already counts as the first attack step
         CLOSED: begin
            g_d = '0;
            if (is_open) begin
               state_d = ATTACK;
               g_d     = g_att;
            end
         end
         ATTACK: begin
            g_d = g_att;
            if (is_below)            state_d = RELEASE;
            else if (g_att == UNITY) state_d = OPEN;
         end
         OPEN: begin
            g_d = UNITY;
            if (is_below) begin
               state_d = HOLD;
               hold_d  = HOLD_LOAD;
            end
         end
         HOLD: begin
            g_d = UNITY;
            if (!is_below)            state_d = OPEN;
            else if (hold_q == '0)    state_d = RELEASE;
            else                      hold_d  = hold_q - HC_W'(1);
         end
         RELEASE: begin
            g_d = g_rel;
            if (is_open)            state_d = ATTACK;
            else if (g_rel == '0)   state_d = CLOSED;
         end
         default: begin
            state_d = CLOSED;
            g_d     = '0;
         end
      endcase
   end

   // Scaling uses the gain before this sample's update; >>> floors toward -inf
   always_comb begin
      gain_x = PW'({1'b0, g_q});
      for (int unsigned i = 0; i < 2; i++) begin
         smp_x[i]  = PW'($signed(audio_in[i]));
         prod[i]   = smp_x[i] * gain_x;
         scaled[i] = DATA_W'(prod[i] >>> 15);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CLOSED;
         g_q     <= '0;
         hold_q  <= '0;
      end else if (sample_valid) begin
         state_q <= state_d;
         g_q     <= g_d;
         hold_q  <= hold_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         audio_out <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= sample_valid;
         if (sample_valid) audio_out <= bypass ? audio_in : scaled;
      end
   end

   assign gate_open = (state_q != CLOSED);

endmodule

// File: tb/tb_fx_noise_gate.sv
// Self-checking bench for fx_noise_gate: behavioural model feeds a scoreboard,
// plus vector tables for the attack ramp and bypass/gap cases.
module tb_fx_noise_gate;

   localparam int DW = 16;
   localparam int S_CLOSED = 0, S_ATTACK = 1, S_OPEN = 2, S_HOLD = 3, S_RELEASE = 4;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [1:0][DW-1:0] audio_in;
   logic               sample_valid;
   logic [6:0]         threshold;
   logic               bypass;
   logic [1:0][DW-1:0] audio_out;
   logic               out_valid;
   logic               gate_open;

   fx_noise_gate #(
      .DATA_W       (16),
      .PARAM_W      (7),
      .HOLD_SAMPLES (480),
      .ATTACK_STEP  (1024),
      .RELEASE_STEP (128),
      .ENV_SH       (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .audio_in     (audio_in),
      .sample_valid (sample_valid),
      .threshold    (threshold),
      .bypass       (bypass),
      .audio_out    (audio_out),
      .out_valid    (out_valid),
      .gate_open    (gate_open)
   );

   always #5 clk = ~clk;

   typedef struct {
      int l;
      int r;
      bit open;
      int cyc;
   } exp_t;

   typedef struct {
      int l;
      int r;
      int gap;
      bit byp;
      int exp_l;
      int exp_r;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;

   int m_env, m_g, m_state, m_hold;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int scale(input int x, input int g);
      longint p;
      p = longint'(x) * longint'(g);
      if (p >= 0) return int'(p / 32768);
      return int'(-((-p + 32767) / 32768));
   endfunction

   task automatic model_reset();
      m_env = 0; m_g = 0; m_state = S_CLOSED; m_hold = 0;
   endtask

   task automatic model_sample(input int l, input int r, output int ol, output int orr,
                               output bit op);
      int al, ar, mag, thr_o, thr_c, gp;
      bit is_o, is_b;
      al  = (l < 0) ? -l : l;
      ar  = (r < 0) ? -r : r;
      mag = (al > ar) ? al : ar;
      if (mag >= m_env) m_env = mag;
      else m_env = m_env - (m_env / 16);
      thr_o = int'(threshold) * 256;
`ifdef NOISE_GATE_HYST_EN
      thr_c = thr_o / 2;
`else
      thr_c = thr_o;
`endif
      is_o = (m_env >= thr_o);
      is_b = (m_env < thr_c);
      gp   = m_g;
      if (bypass) begin
         ol = l; orr = r;
      end else begin
         ol = scale(l, gp); orr = scale(r, gp);
      end
      case (m_state)
         S_CLOSED: begin
            m_g = 0;
            if (is_o) begin m_state = S_ATTACK; m_g = 1024; end
         end
         S_ATTACK: begin
            m_g = (m_g + 1024 > 32768) ? 32768 : m_g + 1024;
            if (is_b) m_state = S_RELEASE;
            else if (m_g == 32768) m_state = S_OPEN;
         end
         S_OPEN: begin
            m_g = 32768;
            if (is_b) begin m_state = S_HOLD; m_hold = 479; end
         end
         S_HOLD: begin
            m_g = 32768;
            if (!is_b) m_state = S_OPEN;
            else if (m_hold == 0) m_state = S_RELEASE;
            else m_hold = m_hold - 1;
         end
         default: begin
            m_g = (m_g < 128) ? 0 : m_g - 128;
            if (is_o) m_state = S_ATTACK;
            else if (m_g == 0) m_state = S_CLOSED;
         end
      endcase
      op = (m_state != S_CLOSED);
   endtask

   // Drives one strobe at posedge+1; use_tab selects table expectations over the model's
   task automatic send(input int l, input int r, input int gap, input bit use_tab,
                       input int tl, input int tr);
      int ol, orr;
      bit op;
      audio_in[0]  = DW'(l);
      audio_in[1]  = DW'(r);
      sample_valid = 1'b1;
      model_sample(l, r, ol, orr, op);
      sb.push_back('{use_tab ? tl : ol, use_tab ? tr : orr, op, cyc + 1});
      @(posedge clk); #1;
      sample_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("valid_cycle", cyc, e.cyc);
               chk("out_l", int'($signed(audio_out[0])), e.l);
               chk("out_r", int'($signed(audio_out[1])), e.r);
               chk("gate_open", int'(gate_open), int'(e.open));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("missing_valid", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ramp_tab[5];
      vec_t byp_tab[8];

      ramp_tab[0] = '{10000, -10000, 0, 1'b0, 0, 0};
      ramp_tab[1] = '{10000, -10000, 0, 1'b0, 312, -313};
      ramp_tab[2] = '{10000, -10000, 0, 1'b0, 625, -625};
      ramp_tab[3] = '{10000, -10000, 0, 1'b0, 937, -938};
      ramp_tab[4] = '{10000, -10000, 0, 1'b0, 1250, -1250};

      byp_tab[0] = '{1234, -1234, 0, 1'b1, 1234, -1234};
      byp_tab[1] = '{-32768, 32767, 1, 1'b1, -32768, 32767};
      byp_tab[2] = '{0, 0, 2, 1'b1, 0, 0};
      byp_tab[3] = '{-1, 1, 3, 1'b1, -1, 1};
      byp_tab[4] = '{20000, 100, 4, 1'b1, 20000, 100};
      byp_tab[5] = '{5, -7, 5, 1'b1, 5, -7};
      byp_tab[6] = '{-20000, 3, 0, 1'b1, -20000, 3};
      byp_tab[7] = '{42, -42, 2, 1'b1, 42, -42};

      reset_n = 1'b0; sample_valid = 1'b0; bypass = 1'b0; threshold = 7'd8;
      audio_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_l", int'($signed(audio_out[0])), 0);
      chk("reset_out_r", int'($signed(audio_out[1])), 0);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_gate", int'(gate_open), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Low-level noise stays gated
      for (int i = 0; i < 1000; i++)
         send((i % 2) ? 100 : -100, (i % 2) ? -100 : 100, 0, 1'b0, 0, 0);
      chk("noise_gate_closed", int'(gate_open), 0);

      // Attack ramp: exact leading values, then model-checked through OPEN
      for (int i = 0; i < 5; i++) begin
         bypass = ramp_tab[i].byp;
         send(ramp_tab[i].l, ramp_tab[i].r, ramp_tab[i].gap, 1'b1,
              ramp_tab[i].exp_l, ramp_tab[i].exp_r);
      end
      for (int i = 0; i < 35; i++) send(10000, -10000, 0, 1'b0, 0, 0);
      chk("open_passthrough", int'($signed(audio_out[1])), -10000);

      // Decay, 480-sample hold, 256-sample release, closed
      for (int i = 0; i < 820; i++) send(500, 500, 0, 1'b0, 0, 0);
      chk("release_closed", int'(gate_open), 0);
      chk("release_out", int'($signed(audio_out[0])), 0);

      // threshold=0 opens immediately and never closes; full-scale negative is exact
      threshold = 7'd0;
      for (int i = 0; i < 40; i++) send(-32768, -32768, 0, 1'b0, 0, 0);
      chk("fullscale_neg", int'($signed(audio_out[0])), -32768);
      for (int i = 0; i < 20; i++) send(0, 0, 1, 1'b0, 0, 0);
      chk("thr0_stays_open", int'(gate_open), 1);

      // Asynchronous reset in the middle of an output cycle
      send(-32768, -32768, 0, 1'b0, 0, 0);
      chk("pre_reset_valid", int'(out_valid), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_out_l", int'($signed(audio_out[0])), 0);
      chk("async_out_r", int'($signed(audio_out[1])), 0);
      chk("async_valid", int'(out_valid), 0);
      chk("async_gate", int'(gate_open), 0);
      sb.delete();
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) send(-32768, -32768, 0, 1'b0, 0, 0);

      // Bypass with irregular strobe spacing; gate keeps tracking
      threshold = 7'd64;
      for (int i = 0; i < 8; i++) begin
         bypass = byp_tab[i].byp;
         send(byp_tab[i].l, byp_tab[i].r, byp_tab[i].gap, 1'b1,
              byp_tab[i].exp_l, byp_tab[i].exp_r);
      end
      bypass = 1'b0;
      for (int i = 0; i < 10; i++) send(3000, -3000, i % 3, 1'b0, 0, 0);

`ifdef NOISE_GATE_HYST_EN
      threshold = 7'd8;
      for (int i = 0; i < 40; i++) send(10000, 10000, 0, 1'b0, 0, 0);
      for (int i = 0; i < 600; i++) send(1500, 1500, 0, 1'b0, 0, 0);
      chk("hyst_stays_open", int'(gate_open), 1);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fx_noise_gate.md
Name: fx_noise_gate

Overview:
Stereo noise gate that sits directly downstream of fx_gain in the effects chain and consumes its stereo output. It tracks a shared peak envelope of both channels. A per-sample state machine opens and closes a Q1.15 gain ramp against a threshold set by a 7-bit parameter. Output is the input scaled by the current gate gain, with a valid strobe, one cycle after each input sample.

Parameters:
DATA_W, 16, signed audio sample width per channel
PARAM_W, 7, threshold parameter width
HOLD_SAMPLES, 480, samples the gate stays open after the envelope falls below threshold (>=1)
ATTACK_STEP, 1024, gate-gain increment per sample in ATTACK
RELEASE_STEP, 128, gate-gain decrement per sample in RELEASE
ENV_SH, 4, envelope decay shift (decay by env>>ENV_SH per sample)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
audio_in  in  [1:0][DATA_W-1:0]  stereo signed samples, index 0 = L
sample_valid  in  1  one-cycle strobe, audio_in valid
threshold  in  PARAM_W  gate threshold parameter
bypass  in  1  1 = pass audio through; FSM keeps tracking
audio_out  out  [1:0][DATA_W-1:0]  gated stereo samples
out_valid  out  1  one-cycle strobe, audio_out valid
gate_open  out  1  1 whenever state != CLOSED

Behaviour:
- Reset: one clock, asynchronous active-low reset_n. All of the following clear immediately and regardless of state: audio_out=0, out_valid=0, gate_open=0, env=0, g=0, hold_cnt=0, state=CLOSED.
- Nothing updates on cycles with sample_valid=0. out_valid is 0 on every cycle except the one after a sample_valid cycle.
- Latency: sample_valid at edge N produces audio_out and out_valid=1 at edge N+1. audio_out holds its value between strobes.
- Magnitude: mag = max(|L|,|R|), DATA_W-bit unsigned, so |-32768| = 32768.
- Envelope update: if mag >= env then env_next = mag, else env_next = env - (env>>ENV_SH).
- Thresholds:
  - thr_open = threshold << (DATA_W-1-PARAM_W), which is threshold*256 at the defaults.
  - thr_close = thr_open, or thr_open>>1 when the optional feature is compiled in.
  - is_open = env_next >= thr_open.
  - is_below = env_next < thr_close.
- Gate gain g: unsigned 16-bit, UNITY=32768. All arithmetic saturates to the range 0..UNITY.
- FSM (evaluated on sample_valid using env_next):
  - CLOSED: g=0. If is_open, go to ATTACK.
  - ATTACK: g += ATTACK_STEP. If g reaches UNITY, go to OPEN. If is_below, go to RELEASE (takes priority over reaching UNITY).
  - OPEN: g=UNITY. If is_below, go to HOLD and load hold_cnt=HOLD_SAMPLES-1.
  - HOLD: g=UNITY. If not is_below, go to OPEN. Else if hold_cnt==0, go to RELEASE. Else hold_cnt decrements.
  - RELEASE: g -= RELEASE_STEP. If is_open, go to ATTACK. Else if g reaches 0, go to CLOSED.
- Scaling: out = (in * g_prev) >>> 15, using a signed product of width DATA_W+17. g_prev is g before this sample's update. Truncation is toward negative infinity. When g_prev=UNITY the output equals the input exactly, including -32768.
- bypass=1: audio_out equals the registered audio_in, with the same latency. env, FSM and g still update normally.
- threshold=0: the gate opens on the first sample and never closes.
- Changing threshold mid-stream takes effect on the next sample_valid.

Optional Feature:
NOISE_GATE_HYST_EN
- Defined: thr_close = thr_open>>1, giving hysteresis.
- Undefined: thr_close = thr_open; no extra logic.

Decomposition:
- Package fx_pkg holds:
  - the gate_state_t enum {CLOSED, ATTACK, OPEN, HOLD, RELEASE};
  - localparam GATE_UNITY = 32768;
  - localparam GATE_W = 16.
- Sub-module fx_env_follower handles abs, stereo max and the envelope register. It outputs env_next and uses the same clk/reset_n.

Test Plan:
1. Reset, threshold=8 (thr 2048), 1000 samples of ±100 -> audio_out=0 on every strobe, gate_open=0, state CLOSED.
2. Then constant L=R=10000 -> first output 0; second 10000*1024>>15=312; third 625; after the 32nd ATTACK step, state OPEN and out=10000.
3. From OPEN, drop input to 500 -> env decays below 2048, then 480 HOLD samples with out=500, then 256 RELEASE samples ramping down, then CLOSED with out=0 and gate_open=0.
4. threshold=0, input -32768 -> gate opens on the first sample; once OPEN, out=-32768 exactly (no overflow).
5. reset_n pulsed low asynchronously mid-OPEN -> all outputs 0 within the same cycle; after release, first output 0 (state CLOSED, g=0).
6. sample_valid gaps of 0..5 cycles plus bypass=1 -> out_valid exactly once per strobe, one cycle late; bypass out=in while gate_open still tracks the envelope.
(With NOISE_GATE_HYST_EN defined) OPEN at threshold=8, input 1500 -> stays OPEN/HOLD and never releases, since 1500 >= 1024.
